// File: rtl/trace_pkg.sv
// Shared definitions for the trace record transmitter.
//   - default field lengths and the record start marker
//   - state and phase encodings used by trace_tx_scheduler
// Optional feature macro: TRACE_TX_CHECKSUM_EN adds the CSUM state.
package trace_pkg;

  localparam int         PT_BYTES_DEF  = 4;
  localparam int         KEY_BYTES_DEF = 8;
  localparam int         CT_BYTES_DEF  = 4;
  localparam int         SAMPLES_DEF   = 1024;
  localparam int         ADDR_W_DEF    = 10;
  localparam logic [7:0] HDR_BYTE_DEF  = 8'hA5;

  // Wide enough for any field byte counter.
  localparam int         CNT_W         = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_PT,
    ST_KEY,
    ST_CT,
    ST_SAM_RD,
    ST_SAM,
`ifdef TRACE_TX_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } state_t;

  // In byte states, SEND strobes the UART and WAIT holds until tx_done.
  // In ST_SAM_RD, SEND presents the address and WAIT captures the read data.
  typedef enum logic {
    PH_SEND,
    PH_WAIT
  } phase_t;

endpackage

// File: rtl/trace_csum8.sv
// 8-bit modulo-256 accumulator.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : zero the sum (has priority over add_en)
//   add_en     : add add_data into the sum this cycle
//   add_data   : byte to accumulate
//   sum_o      : current sum
module trace_csum8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] add_data,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr)         sum_d = 8'h00;
    else if (add_en) sum_d = sum_q + add_data;
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= 8'h00;
    else     sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/trace_tx_scheduler.sv
// Sequences one measurement record onto a shared uart_tx:
//   HDR_BYTE, plaintext, key, ciphertext (each MSB byte first), then SAMPLES
//   bytes read from the trace memory, optionally followed by a checksum byte.
// Optional feature macro: TRACE_TX_CHECKSUM_EN appends the sum mod 256 of
//   every byte after the header.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : record request, accepted only in IDLE
//   pt_i/key_i/ct_i   : record fields, snapshotted on acceptance
//   mem_addr_o        : trace memory address (1-cycle synchronous read)
//   mem_data_i        : trace memory data
//   tx_dv_o/tx_byte_o : uart_tx byte strobe and byte
//   tx_done_i         : uart_tx byte completion
//   tx_active_i       : uart_tx busy, holds off the next strobe
//   busy              : record in progress (acceptance through DONE)
//   done              : 1-cycle pulse after the last byte is acknowledged
module trace_tx_scheduler
  import trace_pkg::*;
#(
  parameter int         PT_BYTES  = PT_BYTES_DEF,
  parameter int         KEY_BYTES = KEY_BYTES_DEF,
  parameter int         CT_BYTES  = CT_BYTES_DEF,
  parameter int         SAMPLES   = SAMPLES_DEF,
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PT_BYTES*8-1:0]  pt_i,
  input  logic [KEY_BYTES*8-1:0] key_i,
  input  logic [CT_BYTES*8-1:0]  ct_i,
  output logic [ADDR_W-1:0]      mem_addr_o,
  input  logic [7:0]             mem_data_i,
  output logic                   tx_dv_o,
  output logic [7:0]             tx_byte_o,
  input  logic                   tx_done_i,
  input  logic                   tx_active_i,
  output logic                   busy,
  output logic                   done
);

  localparam int FW = (PT_BYTES + KEY_BYTES + CT_BYTES) * 8;

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [FW-1:0]     sr_q, sr_d;
  logic [7:0]        tx_byte_q, tx_byte_d;

  logic byte_state, send_fire;

  assign byte_state = (state_q == ST_HDR) || (state_q == ST_PT) || (state_q == ST_KEY) ||
                      (state_q == ST_CT)  || (state_q == ST_SAM)
`ifdef TRACE_TX_CHECKSUM_EN
                      || (state_q == ST_CSUM)
`endif
                      ;
  assign send_fire  = byte_state && (phase_q == PH_SEND) && !tx_active_i;

`ifdef TRACE_TX_CHECKSUM_EN
  logic [7:0] csum_sum;
  logic       csum_clr, csum_add;

  assign csum_clr = (state_q == ST_IDLE) && start;
  // Every strobed byte except the header and the checksum itself.
  assign csum_add = send_fire && (state_q != ST_HDR) && (state_q != ST_CSUM);

  trace_csum8 u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (csum_clr),
    .add_en   (csum_add),
    .add_data (tx_byte_q),
    .sum_o    (csum_sum)
  );
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sr_d      = sr_q;
    tx_byte_d = tx_byte_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d      = {pt_i, key_i, ct_i};
          tx_byte_d = HDR_BYTE;
          cnt_d     = '0;
          idx_d     = '0;
          phase_d   = PH_SEND;
          state_d   = ST_HDR;
        end
      end

      ST_SAM_RD: begin
        if (phase_q == PH_SEND) begin
          phase_d = PH_WAIT;
        end else begin
          tx_byte_d = mem_data_i;
          phase_d   = PH_SEND;
          state_d   = ST_SAM;
        end
      end

      ST_DONE: begin
        phase_d = PH_SEND;
        state_d = ST_IDLE;
      end

      default: begin
        if (phase_q == PH_SEND) begin
          if (send_fire) phase_d = PH_WAIT;
        end else if (tx_done_i) begin
          phase_d = PH_SEND;
          // sr_q's top byte is always the next field byte to go out.
          case (state_q)
            ST_HDR: begin
              state_d   = ST_PT;
              cnt_d     = '0;
              tx_byte_d = sr_q[FW-1 -: 8];
              sr_d      = sr_q << 8;
            end
            ST_PT: begin
              tx_byte_d = sr_q[FW-1 -: 8];
              sr_d      = sr_q << 8;
              if (cnt_q == CNT_W'(PT_BYTES - 1)) begin
                state_d = ST_KEY;
                cnt_d   = '0;
              end else begin
                cnt_d   = cnt_q + 1'b1;
              end
            end
            ST_KEY: begin
              tx_byte_d = sr_q[FW-1 -: 8];
              sr_d      = sr_q << 8;
              if (cnt_q == CNT_W'(KEY_BYTES - 1)) begin
                state_d = ST_CT;
                cnt_d   = '0;
              end else begin
                cnt_d   = cnt_q + 1'b1;
              end
            end
            ST_CT: begin
              if (cnt_q == CNT_W'(CT_BYTES - 1)) begin
                state_d = ST_SAM_RD;
                cnt_d   = '0;
                idx_d   = '0;
              end else begin
                tx_byte_d = sr_q[FW-1 -: 8];
                sr_d      = sr_q << 8;
                cnt_d     = cnt_q + 1'b1;
              end
            end
            ST_SAM: begin
              // Leave on the last index so the address never wraps inside a record.
              if (idx_q == ADDR_W'(SAMPLES - 1)) begin
`ifdef TRACE_TX_CHECKSUM_EN
                state_d   = ST_CSUM;
                tx_byte_d = csum_sum;
`else
                state_d   = ST_DONE;
`endif
              end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_SAM_RD;
              end
            end
            default: state_d = ST_DONE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_SEND;
      cnt_q     <= '0;
      idx_q     <= '0;
      sr_q      <= '0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // Gated by rst so an abort issues no strobe in the reset cycle itself.
  assign tx_dv_o    = send_fire && !rst;
  assign tx_byte_o  = tx_byte_q;
  assign mem_addr_o = idx_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_trace_tx_scheduler.sv
module tb_trace_tx_scheduler;

`ifdef TRACE_TX_CHECKSUM_EN
  localparam int REC_LEN = 1042;
`else
  localparam int REC_LEN = 1041;
`endif
  localparam int LIM = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pt_i = '0;
  logic [63:0] key_i = '0;
  logic [31:0] ct_i = '0;
  logic [9:0]  mem_addr_o;
  logic [7:0]  mem_data_i;
  logic        tx_dv_o;
  logic [7:0]  tx_byte_o;
  logic        tx_done_i;
  logic        tx_active_i;
  logic        busy;
  logic        done;

  trace_tx_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pt_i        (pt_i),
    .key_i       (key_i),
    .ct_i        (ct_i),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .tx_dv_o     (tx_dv_o),
    .tx_byte_o   (tx_byte_o),
    .tx_done_i   (tx_done_i),
    .tx_active_i (tx_active_i),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Trace memory, 1-cycle synchronous read.
  logic [7:0] mem [1024];
  logic [7:0] mem_q = 8'h00;
  always @(posedge clk) mem_q <= mem[mem_addr_o];
  assign mem_data_i = mem_q;

  // uart_tx model: done 10 cycles after each strobe, active in between.
  int         u_cnt = 0;
  logic       u_done = 1'b0, u_act = 1'b0, force_act = 1'b0;
  assign tx_done_i   = u_done;
  assign tx_active_i = u_act | force_act;

  // Monitor
  logic [7:0] got_q[$];
  logic [7:0] inflight = 8'h00;
  int         done_cnt = 0, ovl_err = 0, hold_err = 0, wrap_err = 0, held_err = 0;
  logic       prev_busy = 1'b0;
  logic [9:0] prev_addr = '0;

  always @(posedge clk) begin
    u_done <= 1'b0;
    if (u_cnt > 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) begin
        u_done <= 1'b1;
        u_act  <= 1'b0;
      end
      if (busy && tx_byte_o !== inflight) hold_err <= hold_err + 1;
    end
    if (tx_dv_o) begin
      if (u_cnt > 0 || u_act) ovl_err <= ovl_err + 1;
      if (force_act)          held_err <= held_err + 1;
      u_cnt    <= 9;
      u_act    <= 1'b1;
      inflight <= tx_byte_o;
      got_q.push_back(tx_byte_o);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (prev_busy && busy && prev_addr == 10'd1023 && mem_addr_o == 10'd0) wrap_err <= wrap_err + 1;
    prev_busy <= busy;
    prev_addr <= mem_addr_o;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count bytes of one record differing from header/fields/memory.
  task automatic count_mism(input int base, input logic [127:0] f, output int mism);
    logic [7:0] e;
    mism = 0;
    for (int k = 0; k < 1041; k++) begin
      if (k == 0)       e = 8'hA5;
      else if (k <= 16) e = f[127 - 8*(k-1) -: 8];
      else              e = mem[k-17];
      if (base + k >= got_q.size()) mism++;
      else if (got_q[base+k] !== e) mism++;
    end
  endtask

  task automatic wait_bytes(input int base, input int n);
    for (int c = 0; c < LIM && (got_q.size() - base) < n; c++) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int c = 0; c < LIM && !done; c++) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int            base, d0, mism, held_sz;
  logic [127:0]  f;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_dv",    tx_dv_o,    0);
    chk("rst_tx_byte",  tx_byte_o,  0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_busy",     busy,       0);
    chk("rst_done",     done,       0);
    rst = 1'b0;
    @(negedge clk);

    // Record 1: basic, start re-pulsed in SAM and in DONE
    pt_i  = 32'h65656877;
    key_i = 64'h1918111009080100;
    ct_i  = 32'hC69BE9BB;
    f     = {pt_i, key_i, ct_i};
    base  = got_q.size();
    d0    = done_cnt;
    pulse_start();
    pt_i = 32'hDEADBEEF; key_i = '1; ct_i = 32'h12345678;
    chk("r1_first_dv",   tx_dv_o,   1);
    chk("r1_first_byte", tx_byte_o, 8'hA5);
    chk("r1_busy",       busy,      1);
    wait_bytes(base, 500);
    chk("r1_reach_sam", 32'(got_q.size() - base), 500);
    pulse_start();
    wait_done();
    chk("r1_done_seen", done, 1);
    pulse_start();
    chk("r1_busy_after_done", busy, 0);
    repeat (40) @(negedge clk);
    chk("r1_busy_idle",  busy, 0);
    chk("r1_len",        32'(got_q.size() - base), REC_LEN);
    chk("r1_done_cnt",   32'(done_cnt - d0), 1);
    count_mism(base, f, mism);
    chk("r1_bytes", 32'(mism), 0);
    chk("r1_byte5", got_q[base+5], 8'h19);
    chk("r1_last_sample", got_q[base+1040], 8'hFF);
`ifdef TRACE_TX_CHECKSUM_EN
    chk("r1_csum", got_q[base+1041], 8'h12);
`endif

    // Record 2: memory latency edges and tx_active hold-off
    mem[0]    = 8'hFA;
    mem[1023] = 8'hFF;
    pt_i  = 32'h01020304;
    key_i = 64'hA0B0C0D0E0F01020;
    ct_i  = 32'h0F1E2D3C;
    f     = {pt_i, key_i, ct_i};
    base  = got_q.size();
    d0    = done_cnt;
    pulse_start();
    wait_bytes(base, 4);
    for (int c = 0; c < 100 && !tx_done_i; c++) @(negedge clk);
    chk("r2_ack_seen", tx_done_i, 1);
    force_act = 1'b1;
    repeat (50) @(negedge clk);
    held_sz = got_q.size() - base;
    force_act = 1'b0;
    chk("r2_held_len", 32'(held_sz), 4);
    chk("r2_held_dv",  32'(held_err), 0);
    wait_done();
    chk("r2_done_seen", done, 1);
    repeat (40) @(negedge clk);
    chk("r2_len",      32'(got_q.size() - base), REC_LEN);
    chk("r2_done_cnt", 32'(done_cnt - d0), 1);
    count_mism(base, f, mism);
    chk("r2_bytes", 32'(mism), 0);
    chk("r2_first_sample", got_q[base+17],   8'hFA);
    chk("r2_last_sample",  got_q[base+1040], 8'hFF);

    // Record 3: reset during KEY byte 3
    base = got_q.size();
    d0   = done_cnt;
    pulse_start();
    wait_bytes(base, 8);
    chk("r3_reach_key3", 32'(got_q.size() - base), 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r3_abort_busy",  busy,       0);
    chk("r3_abort_dv",    tx_dv_o,    0);
    chk("r3_abort_done",  done,       0);
    chk("r3_abort_addr",  mem_addr_o, 0);
    repeat (50) @(negedge clk);
    chk("r3_no_more_dv", 32'(got_q.size() - base), 8);
    chk("r3_no_done",    32'(done_cnt - d0), 0);

    // Record 4: full record after the abort
    pt_i  = 32'h65656877;
    key_i = 64'h1918111009080100;
    ct_i  = 32'hC69BE9BB;
    f     = {pt_i, key_i, ct_i};
    base  = got_q.size();
    d0    = done_cnt;
    pulse_start();
    wait_done();
    chk("r4_done_seen", done, 1);
    repeat (40) @(negedge clk);
    chk("r4_len",       32'(got_q.size() - base), REC_LEN);
    chk("r4_hdr",       got_q[base], 8'hA5);
    chk("r4_done_cnt",  32'(done_cnt - d0), 1);
    count_mism(base, f, mism);
    chk("r4_bytes", 32'(mism), 0);

    // Global protocol checks
    chk("no_overlap_dv", 32'(ovl_err),  0);
    chk("byte_held",     32'(hold_err), 0);
    chk("addr_no_wrap",  32'(wrap_err), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
